halt_sleep_ctrl: RTL and testbench
==================================

Name: halt_sleep_ctrl

Overview:
- Responder side of the CPU HALT/SLP instructions.
- The instruction decoder pulses a request when it executes HALT or SLP.
- This block then freezes CPU execution (and, for SLP, the OSC1 timer domain) until a qualifying wake event arrives, and releases the CPU with a wake pulse and a reason code.
- Sits between the CPU core, the interrupt controller and the clock/tick generator.

Parameters:
- RESTART_TICKS, 16: clk_en ticks of oscillator restart delay after an SLP wake before the CPU resumes. 0 = no delay.
- IRQ_COUNT, 6: number of interrupt pending lines monitored.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clk_en  in  1  CPU tick enable; counts restart delay
- halt_req  in  1  one-clk pulse, decoder executed HALT
- sleep_req  in  1  one-clk pulse, decoder executed SLP
- irq_pending  in  IRQ_COUNT  level, per-source pending-and-unmasked interrupt flags
- irq_enable  in  1  CPU I flag
- key_wake  in  1  level, K0x key-input interrupt pending
- cpu_run  out  1  CPU microcode advance enable
- osc_stop  out  1  stop OSC1-derived timers/prescaler
- halted  out  1  in HALT state
- sleeping  out  1  in SLEEP or RESTART state
- wake_pulse  out  1  one-clk pulse when the CPU resumes
- wake_src  out  2  last wake reason: 0 none, 1 irq (HALT), 2 key (SLP)

Behaviour:
- Reset (async assert, sync release):
  - state RUN, counter 0.
  - cpu_run=1, osc_stop=0, halted=0, sleeping=0, wake_pulse=0, wake_src=0.
- Reset asserted in any state forces RUN immediately, with no wake_pulse.
- States and registered outputs:
  - RUN: cpu_run=1, others 0.
  - HALT: cpu_run=0, halted=1.
  - SLEEP: cpu_run=0, sleeping=1, osc_stop=1.
  - RESTART: cpu_run=0, sleeping=1, osc_stop=0.
- All outputs are registered and change on the clk edge of the state transition.
- RUN transitions:
  - sleep_req=1 -> SLEEP next cycle. sleep_req wins if both requests are high in the same cycle.
  - else halt_req=1 -> HALT next cycle.
  - Requests are sampled every clk, independent of clk_en.
  - Requests arriving in any state other than RUN are ignored.
- HALT transitions:
  - irq_enable & |irq_pending -> RUN next cycle, with wake_pulse=1 for exactly that cycle and wake_src=1.
  - With irq_enable=0 or no pending irq, HALT is held indefinitely.
  - If the wake condition is already true in the cycle halt_req is accepted, HALT lasts exactly 1 clk, then RUN.
- SLEEP transitions:
  - irq_enable & key_wake -> RESTART next cycle; counter loads 0.
  - irq_pending is ignored in SLEEP; only key_wake wakes.
  - With irq_enable=0 the only exit is reset.
- RESTART transitions:
  - Counter increments on each clk_en=1 cycle.
  - When counter reaches RESTART_TICKS -> RUN on the following clk edge, with wake_pulse=1 and wake_src=2.
  - RESTART_TICKS=0 -> RUN on the cycle after entering RESTART.
  - key_wake deasserting during RESTART does not abort the restart.
- wake_src holds its value until the next accepted halt_req/sleep_req, which clears it to 0.
- Counter width is $clog2(RESTART_TICKS+1), minimum 1. The counter saturates and never wraps.
- wake_pulse never asserts in the same cycle as halted or osc_stop.

Test Plan:
1. halt_req pulse, irq_enable=1, irq_pending=0 for 20 cycles, then irq_pending=6'b000100 -> halted=1/cpu_run=0 throughout the wait; 1 cycle after irq: cpu_run=1, wake_pulse=1 for exactly 1 clk, wake_src=1.
2. HALT with irq_enable=0 and irq_pending=6'b111111 for 50 cycles -> stays halted; raise irq_enable -> wakes next cycle, wake_src=1.
3. sleep_req, then irq_pending=6'b000001 (ignored), then key_wake=1 with clk_en every 4th clk, RESTART_TICKS=16 -> osc_stop=1 until key; then osc_stop=0, cpu_run=0 for 16 ticks (~64 clk); then wake_pulse, wake_src=2.
4. halt_req and sleep_req in the same cycle -> SLEEP (osc_stop=1, halted=0). halt_req issued while in SLEEP -> no change.
5. halt_req with irq_enable=1 and irq_pending already nonzero -> halted=1 for exactly 1 clk, then wake_pulse.
6. reset_n asserted mid-RESTART and mid-HALT -> outputs immediately reach reset values (cpu_run=1, wake_src=0), no wake_pulse. After release, a new halt_req behaves normally.

Source files
------------

// File: rtl/halt_sleep_ctrl.sv
// rtl/halt_sleep_ctrl.sv - HALT/SLP responder: freezes the CPU and OSC1 domain until a wake event arrives
module halt_sleep_ctrl #(
    parameter int RESTART_TICKS = 16,
    parameter int IRQ_COUNT     = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clk_en,
    input  logic                 halt_req,
    input  logic                 sleep_req,
    input  logic [IRQ_COUNT-1:0] irq_pending,
    input  logic                 irq_enable,
    input  logic                 key_wake,
    output logic                 cpu_run,
    output logic                 osc_stop,
    output logic                 halted,
    output logic                 sleeping,
    output logic                 wake_pulse,
    output logic [1:0]           wake_src
);

    localparam int CW = (RESTART_TICKS < 1) ? 1 : $clog2(RESTART_TICKS + 1);
    localparam logic [CW-1:0] TICKS = CW'(RESTART_TICKS);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALT    = 2'd1,
        ST_SLEEP   = 2'd2,
        ST_RESTART = 2'd3
    } state_t;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_IRQ  = 2'd1;
    localparam logic [1:0] SRC_KEY  = 2'd2;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          cpu_run_q;
    logic          osc_stop_q;
    logic          halted_q;
    logic          sleeping_q;
    logic          wake_pulse_q;
    logic [1:0]    wake_src_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            cpu_run_q    <= 1'b1;
            osc_stop_q   <= 1'b0;
            halted_q     <= 1'b0;
            sleeping_q   <= 1'b0;
            wake_pulse_q <= 1'b0;
            wake_src_q   <= SRC_NONE;
        end else begin
            wake_pulse_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    // SLP has priority when the decoder raises both requests together
                    if (sleep_req) begin
                        state_q    <= ST_SLEEP;
                        cpu_run_q  <= 1'b0;
                        sleeping_q <= 1'b1;
                        osc_stop_q <= 1'b1;
                        wake_src_q <= SRC_NONE;
                    end else if (halt_req) begin
                        state_q    <= ST_HALT;
                        cpu_run_q  <= 1'b0;
                        halted_q   <= 1'b1;
                        wake_src_q <= SRC_NONE;
                    end
                end
                ST_HALT: begin
                    if (irq_enable && (|irq_pending)) begin
                        state_q      <= ST_RUN;
                        cpu_run_q    <= 1'b1;
                        halted_q     <= 1'b0;
                        wake_pulse_q <= 1'b1;
                        wake_src_q   <= SRC_IRQ;
                    end
                end
                ST_SLEEP: begin
                    if (irq_enable && key_wake) begin
                        state_q    <= ST_RESTART;
                        osc_stop_q <= 1'b0;
                        cnt_q      <= '0;
                    end
                end
                ST_RESTART: begin
                    // Oscillator settles for RESTART_TICKS ticks; key release no longer matters here
                    if (cnt_q == TICKS) begin
                        state_q      <= ST_RUN;
                        cpu_run_q    <= 1'b1;
                        sleeping_q   <= 1'b0;
                        wake_pulse_q <= 1'b1;
                        wake_src_q   <= SRC_KEY;
                    end else if (clk_en && (cnt_q != {CW{1'b1}})) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q    <= ST_RUN;
                    cpu_run_q  <= 1'b1;
                    osc_stop_q <= 1'b0;
                    halted_q   <= 1'b0;
                    sleeping_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_run    = cpu_run_q;
    assign osc_stop   = osc_stop_q;
    assign halted     = halted_q;
    assign sleeping   = sleeping_q;
    assign wake_pulse = wake_pulse_q;
    assign wake_src   = wake_src_q;

endmodule

// File: tb/tb_halt_sleep_ctrl.sv
// tb/tb_halt_sleep_ctrl.sv - directed self-checking bench for halt_sleep_ctrl
module tb_halt_sleep_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clk_en;
    logic       halt_req;
    logic       sleep_req;
    logic [5:0] irq_pending;
    logic       irq_enable;
    logic       key_wake;
    logic       cpu_run;
    logic       osc_stop;
    logic       halted;
    logic       sleeping;
    logic       wake_pulse;
    logic [1:0] wake_src;

    int checks = 0;
    int errors = 0;

    halt_sleep_ctrl #(.RESTART_TICKS(16), .IRQ_COUNT(6)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_en     (clk_en),
        .halt_req   (halt_req),
        .sleep_req  (sleep_req),
        .irq_pending(irq_pending),
        .irq_enable (irq_enable),
        .key_wake   (key_wake),
        .cpu_run    (cpu_run),
        .osc_stop   (osc_stop),
        .halted     (halted),
        .sleeping   (sleeping),
        .wake_pulse (wake_pulse),
        .wake_src   (wake_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_halt();
        halt_req = 1'b1;
        tick(1);
        halt_req = 1'b0;
    endtask

    task automatic pulse_sleep();
        sleep_req = 1'b1;
        tick(1);
        sleep_req = 1'b0;
    endtask

    initial begin
        int  n;
        logic bad;

        reset_n = 1'b0; clk_en = 1'b1; halt_req = 1'b0; sleep_req = 1'b0;
        irq_pending = '0; irq_enable = 1'b1; key_wake = 1'b0;
        tick(3);
        check("rst_cpu_run", cpu_run, 1);
        check("rst_osc_stop", osc_stop, 0);
        check("rst_halted", halted, 0);
        check("rst_sleeping", sleeping, 0);
        check("rst_wake_pulse", wake_pulse, 0);
        check("rst_wake_src", wake_src, 0);
        reset_n = 1'b1;
        tick(2);

        // 1: HALT waits 20 cycles, then irq wakes it
        pulse_halt();
        check("t1_halted", halted, 1);
        check("t1_cpu_run", cpu_run, 0);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (!halted || cpu_run || wake_pulse) bad = 1'b1;
        end
        check("t1_hold", bad, 0);
        irq_pending = 6'b000100;
        tick(1);
        check("t1_wake_pulse", wake_pulse, 1);
        check("t1_cpu_run_after", cpu_run, 1);
        check("t1_halted_after", halted, 0);
        check("t1_wake_src", wake_src, 1);
        irq_pending = '0;
        tick(1);
        check("t1_pulse_width", wake_pulse, 0);
        check("t1_src_hold", wake_src, 1);

        // 2: interrupts masked keep HALT, unmasking wakes
        irq_enable = 1'b0;
        pulse_halt();
        check("t2_src_clear", wake_src, 0);
        irq_pending = 6'b111111;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (!halted || cpu_run || wake_pulse) bad = 1'b1;
        end
        check("t2_hold", bad, 0);
        irq_enable = 1'b1;
        tick(1);
        check("t2_wake_pulse", wake_pulse, 1);
        check("t2_wake_src", wake_src, 1);
        check("t2_halted", halted, 0);
        irq_pending = '0;
        tick(1);

        // 3: SLP ignores irqs, key wakes, 16 ticks at clk_en every 4th clk
        pulse_sleep();
        check("t3_osc_stop", osc_stop, 1);
        check("t3_sleeping", sleeping, 1);
        check("t3_src_clear", wake_src, 0);
        irq_pending = 6'b000001;
        tick(5);
        check("t3_irq_ignored", osc_stop, 1);
        check("t3_cpu_run_sleep", cpu_run, 0);
        irq_pending = '0;
        clk_en = 1'b0;
        key_wake = 1'b1;
        tick(1);
        key_wake = 1'b0;
        check("t3_restart_osc", osc_stop, 0);
        check("t3_restart_sleeping", sleeping, 1);
        check("t3_restart_cpu", cpu_run, 0);
        n = 0;
        bad = 1'b0;
        while (!wake_pulse && n < 200) begin
            clk_en = ((n % 4) == 3);
            tick(1);
            n++;
            if (!wake_pulse && (osc_stop || cpu_run || !sleeping)) bad = 1'b1;
        end
        check("t3_restart_clks", n, 65);
        check("t3_restart_hold", bad, 0);
        check("t3_wake_src", wake_src, 2);
        check("t3_cpu_run", cpu_run, 1);
        check("t3_sleeping_off", sleeping, 0);
        clk_en = 1'b1;
        tick(1);

        // 4: simultaneous requests pick SLEEP; HALT during SLEEP ignored
        halt_req = 1'b1; sleep_req = 1'b1;
        tick(1);
        halt_req = 1'b0; sleep_req = 1'b0;
        check("t4_osc_stop", osc_stop, 1);
        check("t4_halted", halted, 0);
        pulse_halt();
        tick(1);
        check("t4_ignore_halted", halted, 0);
        check("t4_ignore_osc", osc_stop, 1);
        key_wake = 1'b1;
        tick(1);
        key_wake = 1'b0;
        n = 0;
        while (!wake_pulse && n < 100) begin
            tick(1);
            n++;
        end
        check("t4_restart_clks", n, 17);
        check("t4_wake_src", wake_src, 2);
        tick(1);

        // 5: wake condition already true -> HALT lasts one clk
        irq_pending = 6'b000100;
        pulse_halt();
        check("t5_halted", halted, 1);
        tick(1);
        check("t5_halted_off", halted, 0);
        check("t5_wake_pulse", wake_pulse, 1);
        check("t5_wake_src", wake_src, 1);
        irq_pending = '0;
        tick(1);

        // 6: reset mid-RESTART and mid-HALT, then normal HALT
        pulse_sleep();
        key_wake = 1'b1;
        tick(1);
        key_wake = 1'b0;
        tick(3);
        check("t6_in_restart", sleeping, 1);
        reset_n = 1'b0;
        #2;
        check("t6a_cpu_run", cpu_run, 1);
        check("t6a_sleeping", sleeping, 0);
        check("t6a_osc_stop", osc_stop, 0);
        check("t6a_wake_src", wake_src, 0);
        check("t6a_wake_pulse", wake_pulse, 0);
        tick(2);
        check("t6a_no_pulse", wake_pulse, 0);
        reset_n = 1'b1;
        tick(1);
        irq_enable = 1'b0;
        pulse_halt();
        tick(3);
        check("t6_in_halt", halted, 1);
        reset_n = 1'b0;
        #2;
        check("t6b_halted", halted, 0);
        check("t6b_cpu_run", cpu_run, 1);
        check("t6b_wake_pulse", wake_pulse, 0);
        tick(1);
        reset_n = 1'b1;
        irq_enable = 1'b1;
        tick(1);
        pulse_halt();
        check("t6c_halted", halted, 1);
        irq_pending = 6'b100000;
        tick(1);
        check("t6c_wake_pulse", wake_pulse, 1);
        check("t6c_wake_src", wake_src, 1);
        irq_pending = '0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
